breakout_state_ctrl: RTL
========================

// Module: breakout_state_ctrl
// PURPOSE
//   Top-level game sequencer for the breakout core: decides when the core runs, when a game
//   restarts, when a ball is re-served and when the brick field refills. Sits between the
//   debounced UI buttons and the game core (drives game_run/new_game/serve_ball/refill_bricks;
//   reads ball_lost/bricks_alive/score). Also tracks lives, level and session high score.
// PARAMETERS
//   LIVES_INIT  3      lives loaded at new game; legal range 1..7
//   SERVE_CYC   6_000_000   cycles spent in SERVE before play starts (>=1)
//   MISS_CYC    50_000_000  cycles spent in MISS after a lost ball (>=1)
//   CLEAR_CYC   50_000_000  cycles spent in CLEAR after field cleared (>=1)
//   OVER_CYC    500_000_000 cycles in OVER before falling back to ATTRACT (>=1)
// PORTS
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   start_btn      in   1   debounced start level (sync to clk)
//   pause_btn      in   1   debounced pause level (sync to clk)
//   ball_lost      in   1   core's latched ball-lost flag
//   bricks_alive   in   48  core's brick alive mask
//   score          in   10  core's current score
//   game_run       out  1   core run enable
//   new_game       out  1   1-cycle pulse: core resets score, ball, bricks
//   serve_ball     out  1   1-cycle pulse: core re-serves ball, clears ball_lost
//   refill_bricks  out  1   1-cycle pulse: core restores all bricks/HP, keeps score
//   lives          out  3   remaining lives
//   level          out  4   current level, 1..15
//   high_score     out  10  best final score since reset
//   state_o        out  3   ATTRACT=0 SERVE=1 PLAY=2 PAUSE=3 MISS=4 CLEAR=5 OVER=6
// BEHAVIOUR
// - Async reset: state ATTRACT, game_run=0, all pulses 0, lives=LIVES_INIT, level=1,
//   high_score=0, timer=0, button history regs=0. Reset mid-game aborts instantly.
// - All outputs registered. game_run==1 exactly in cycles where state_o==PLAY.
// - start_e/pause_e: rising edges (btn & ~btn_q); levels held high do not retrigger.
// - Timer: loaded with X_CYC-1 on entry to a timed state, decrements each cycle; exit when
//   timer==0, so dwell is exactly X_CYC cycles. Width = $clog2 of largest *_CYC.
// - ATTRACT: start_e -> SERVE; same edge: new_game=1 (one cycle), lives=LIVES_INIT, level=1.
// - SERVE: game_run=0; ball_lost/bricks/buttons ignored; timer expiry -> PLAY.
// - PLAY, priority high->low: ball_lost=1 -> MISS, lives<=lives-1;
//   bricks_alive==0 -> CLEAR, level<=min(level+1,15); pause_e -> PAUSE.
// - PAUSE: game_run=0; pause_e -> PLAY (no timer); start_e ignored.
// - MISS: expiry: lives==0 -> OVER; else SERVE with serve_ball=1 on the transition.
// - CLEAR: expiry -> SERVE with refill_bricks=1 and serve_ball=1 on the same cycle.
// - OVER: on entry high_score<=score if score>high_score (unsigned compare). start_e ->
//   SERVE exactly as from ATTRACT (new_game, lives, level reloaded); expiry -> ATTRACT.
// - lives never decremented below 0; lives only change in ATTRACT/OVER start or PLAY->MISS.
// - Simultaneous ball_lost & cleared field: MISS wins, level not incremented.
// - Pulse outputs high for exactly one cycle and never overlap except refill+serve.
// TESTING (use SERVE_CYC=4 MISS_CYC=3 CLEAR_CYC=3 OVER_CYC=8, LIVES_INIT=3)
// - Reset then start_btn 0->1: new_game high 1 cycle, state 1 for 4 cycles, then state 2 with
//   game_run=1; start held high causes no second new_game.
// - In PLAY assert ball_lost: next cycle state 4, lives 2, game_run 0; after 3 cycles
//   serve_ball pulse, state 1; drop ball_lost on pulse; PLAY again after 4 cycles.
// - Three misses: lives 3->2->1->0, third MISS -> state 6; score=37 with high_score=20 ->
//   high_score 37; no start for 8 cycles -> state 0; retry with score=10 keeps 37.
// - In PLAY set bricks_alive=0: state 5, level 1->2; after 3 cycles refill_bricks and
//   serve_ball both high one cycle; repeat 20 clears -> level saturates at 15.
// - Pause edge in PLAY -> state 3, game_run 0; second edge -> state 2; pause edge same
//   cycle as ball_lost -> state 4; ball_lost with bricks_alive=0 -> state 4, level unchanged.
// - Assert reset during PAUSE and during MISS: outputs at reset values same cycle, state 0.

Source files
------------

// File: rtl/breakout_state_ctrl.sv
// Game sequencer for the breakout core: run/serve/refill control plus lives, level
// and session high score bookkeeping.
module breakout_state_ctrl #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned SERVE_CYC  = 6_000_000,
    parameter int unsigned MISS_CYC   = 50_000_000,
    parameter int unsigned CLEAR_CYC  = 50_000_000,
    parameter int unsigned OVER_CYC   = 500_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        ball_lost,
    input  logic [47:0] bricks_alive,
    input  logic [9:0]  score,
    output logic        game_run,
    output logic        new_game,
    output logic        serve_ball,
    output logic        refill_bricks,
    output logic [2:0]  lives,
    output logic [3:0]  level,
    output logic [9:0]  high_score,
    output logic [2:0]  state_o
);

    localparam int unsigned MAX_A   = (SERVE_CYC > MISS_CYC) ? SERVE_CYC : MISS_CYC;
    localparam int unsigned MAX_B   = (CLEAR_CYC > OVER_CYC) ? CLEAR_CYC : OVER_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_MISS    = 3'd4,
        ST_CLEAR   = 3'd5,
        ST_OVER    = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          start_q, pause_q;
    logic          start_e, pause_e;
    logic          game_run_nxt, new_game_nxt, serve_ball_nxt, refill_bricks_nxt;
    logic [2:0]    lives_nxt;
    logic [3:0]    level_nxt;
    logic [9:0]    high_score_nxt;

    assign start_e = start_btn & ~start_q;
    assign pause_e = pause_btn & ~pause_q;
    assign state_o = state;

    // State, dwell timer and button history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_ATTRACT;
            timer   <= '0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            start_q <= start_btn;
            pause_q <= pause_btn;
        end
    end

    // Next state; the timer is reloaded with X_CYC-1 on every entry to a timed state
    always_comb begin
        state_nxt = state;
        timer_nxt = (timer == '0) ? '0 : timer - TW'(1);
        case (state)
            ST_ATTRACT: begin
                if (start_e) begin
                    state_nxt = ST_SERVE;
                    timer_nxt = TW'(SERVE_CYC - 1);
                end
            end
            ST_SERVE: begin
                if (timer == '0) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (ball_lost) begin
                    state_nxt = ST_MISS;
                    timer_nxt = TW'(MISS_CYC - 1);
                end else if (bricks_alive == '0) begin
                    state_nxt = ST_CLEAR;
                    timer_nxt = TW'(CLEAR_CYC - 1);
                end else if (pause_e) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_e) state_nxt = ST_PLAY;
            end
            ST_MISS: begin
                if (timer == '0) begin
                    if (lives == '0) begin
                        state_nxt = ST_OVER;
                        timer_nxt = TW'(OVER_CYC - 1);
                    end else begin
                        state_nxt = ST_SERVE;
                        timer_nxt = TW'(SERVE_CYC - 1);
                    end
                end
            end
            ST_CLEAR: begin
                if (timer == '0) begin
                    state_nxt = ST_SERVE;
                    timer_nxt = TW'(SERVE_CYC - 1);
                end
            end
            ST_OVER: begin
                if (start_e) begin
                    state_nxt = ST_SERVE;
                    timer_nxt = TW'(SERVE_CYC - 1);
                end else if (timer == '0) begin
                    state_nxt = ST_ATTRACT;
                end
            end
            default: state_nxt = ST_ATTRACT;
        endcase
    end

    // Output values for the coming cycle, derived from the transition being taken
    always_comb begin
        game_run_nxt      = (state_nxt == ST_PLAY);
        new_game_nxt      = 1'b0;
        serve_ball_nxt    = 1'b0;
        refill_bricks_nxt = 1'b0;
        lives_nxt         = lives;
        level_nxt         = level;
        high_score_nxt    = high_score;

        if ((state == ST_ATTRACT || state == ST_OVER) && state_nxt == ST_SERVE) begin
            new_game_nxt = 1'b1;
            lives_nxt    = 3'(LIVES_INIT);
            level_nxt    = 4'd1;
        end
        if ((state == ST_MISS || state == ST_CLEAR) && state_nxt == ST_SERVE) begin
            serve_ball_nxt = 1'b1;
        end
        if (state == ST_CLEAR && state_nxt == ST_SERVE) begin
            refill_bricks_nxt = 1'b1;
        end
        if (state == ST_PLAY && state_nxt == ST_MISS && lives != 3'd0) begin
            lives_nxt = lives - 3'd1;
        end
        if (state == ST_PLAY && state_nxt == ST_CLEAR && level != 4'd15) begin
            level_nxt = level + 4'd1;
        end
        if (state == ST_MISS && state_nxt == ST_OVER && score > high_score) begin
            high_score_nxt = score;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_run      <= 1'b0;
            new_game      <= 1'b0;
            serve_ball    <= 1'b0;
            refill_bricks <= 1'b0;
            lives         <= 3'(LIVES_INIT);
            level         <= 4'd1;
            high_score    <= '0;
        end else begin
            game_run      <= game_run_nxt;
            new_game      <= new_game_nxt;
            serve_ball    <= serve_ball_nxt;
            refill_bricks <= refill_bricks_nxt;
            lives         <= lives_nxt;
            level         <= level_nxt;
            high_score    <= high_score_nxt;
        end
    end

endmodule
